led_effect_sequencer: RTL and testbench
=======================================

Name: led_effect_sequencer

Overview:
Top-level LED effect controller for the 16-LED board output. It owns the shared timebase (µs/ms ticks) and the single PWM brightness comparator. A mode state machine steps through OFF, BREATH, CHASE and BLINK on a debounced button press. A pause input freezes the active effect without losing its position.

Parameters:
CLK_PER_US, 100, system_clk cycles per µs tick (100 MHz clock).
US_PER_MS, 1000, µs ticks per ms tick; also the PWM period in µs ticks and the number of breath levels.
DEBOUNCE_MS, 20, consecutive equal ms samples needed to accept a button level.
CHASE_MS, 125, ms per chase step.
BLINK_MS, 500, ms per blink half-period.

Ports:
system_clk  in  1  sole clock, rising edge.
rst  in  1  synchronous, active-high reset.
btn_next  in  1  raw asynchronous push button; press = 1.
pause  in  1  level input; 1 freezes effect progression. Synchronised internally.
mode  out  2  current mode: 0 OFF, 1 BREATH, 2 CHASE, 3 BLINK.
mode_change  out  1  one-cycle pulse on the cycle mode updates.
light  out  16  registered LED drive.

Behaviour:
- Reset and clocking: one clock; reset is synchronous and active-high. On rst=1, all counters are 0, mode=0, mode_change=0, light=16'h0000, debounced level=0, and both synchronisers are cleared.
- Timebase: us_cnt counts 0..CLK_PER_US-1 and wraps. tick_us=1 in the cycle us_cnt==CLK_PER_US-1. ms_cnt counts 0..US_PER_MS-1 on tick_us. tick_ms = tick_us && ms_cnt==US_PER_MS-1. The timebase is never paused.
- Button path: 2-flop synchroniser, then a debouncer sampled only on tick_ms. A counter increments while the sample differs from the debounced level and clears when they are equal. When it reaches DEBOUNCE_MS, the debounced level takes the sample and the counter clears.
  - A 0->1 transition of the debounced level gives one-cycle press pulse P. Release produces nothing.
- Mode FSM: OFF->BREATH->CHASE->BLINK->OFF, advancing one step per P. Mode is registered: it changes in the cycle after P, with mode_change=1 in that same cycle. pause does not block mode changes.
- On every mode entry (the cycle mode_change=1), the effect state resets: lvl=0, dir=up, chase_idx=0, blink_cnt=0, blink_on=1.
- BREATH:
  - lvl (0..US_PER_MS-1) increments on tick_ms while pause=0.
  - At lvl==US_PER_MS-1 with tick_ms, lvl wraps to 0 and dir toggles.
  - pwm = (ms_cnt < lvl) when dir=up, else (ms_cnt >= lvl).
  - light = {16{pwm}}, registered, so light lags by 1 cycle.
- CHASE:
  - A step counter counts ms ticks; at CHASE_MS ticks it clears and chase_idx increments, wrapping 15->0.
  - light = one-hot(chase_idx), with bit 0 first after entry.
- BLINK:
  - blink_cnt counts ms ticks; at BLINK_MS ticks it clears and blink_on toggles.
  - light = blink_on ? 16'hFFFF : 16'h0000.
- OFF: light = 0. Effect counters hold.
- Pause: synchronised pause=1 holds lvl, dir, chase_idx, blink_cnt, blink_on and the step counters. The PWM comparison keeps running, so a paused BREATH holds a constant duty.
- Simultaneous events:
  - P and an effect-step tick in the same cycle: the mode entry reset wins.
  - pause and P together: the mode advances, and the new effect starts frozen at its entry values.
- Reset mid-operation: rst=1 in any cycle overrides everything. The next cycle shows the reset values regardless of mode, pause or button state.
- Widths: every counter is sized from its parameter with $clog2, with no truncation at the maximum value. Comparisons are unsigned.

Test Plan:
Use CLK_PER_US=2, US_PER_MS=8, DEBOUNCE_MS=2, CHASE_MS=1, BLINK_MS=2 (one ms tick every 16 cycles).
1. Reset/idle: rst held 3 cycles then released, no button activity -> mode=0, light=0, mode_change never asserted over 500 cycles; tick_ms period measures 16 cycles.
2. Debounce: btn_next glitch high for 20 cycles (≤1 ms sample) -> no mode change. Btn_next held high 60 cycles -> exactly one mode_change pulse, mode=1; release and hold high again -> mode=2. Seventh, eighth and ninth accepted presses -> modes 3, 0, 1 (wrap).
3. BREATH duty: in mode 1 with lvl=3, dir=up -> light=16'hFFFF for 3 of every 8 ms-window µs ticks, i.e. 6 of 16 cycles. After 8 ms, dir=down and duty becomes 5/8.
4. CHASE wrap: enter mode 2 -> light=16'h0001, then 16'h0002 after 16 cycles, ..., 16'h8000, then 16'h0001 again after 16 steps (256 cycles).
5. Pause/BLINK: in mode 3, blink_on toggles every 32 cycles. Assert pause -> light frozen for 200 cycles. Deassert -> toggling resumes with remaining blink_cnt preserved.
6. Reset mid-effect: rst pulsed during CHASE at chase_idx=9 -> next cycle mode=0, light=0. A subsequent press enters BREATH with lvl=0.

Source files
------------

// File: rtl/led_effect_sequencer.sv
// 16-LED effect controller: shared us/ms timebase, debounced mode button,
// and BREATH / CHASE / BLINK effects on one registered LED bus.
module led_effect_sequencer #(
    parameter int unsigned CLK_PER_US  = 100,
    parameter int unsigned US_PER_MS   = 1000,
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned CHASE_MS    = 125,
    parameter int unsigned BLINK_MS    = 500
) (
    input  logic        system_clk,
    input  logic        rst,
    input  logic        btn_next,
    input  logic        pause,
    output logic [1:0]  mode,
    output logic        mode_change,
    output logic [15:0] light
);

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_BREATH = 2'd1,
        MODE_CHASE  = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_e;

    localparam int unsigned US_W  = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam int unsigned MS_W  = (US_PER_MS > 1) ? $clog2(US_PER_MS) : 1;
    localparam int unsigned DB_W  = $clog2(DEBOUNCE_MS + 1);
    localparam int unsigned CH_W  = $clog2(CHASE_MS + 1);
    localparam int unsigned BL_W  = $clog2(BLINK_MS + 1);
    localparam int unsigned IDX_W = 4;

    localparam logic [US_W-1:0] US_LAST = US_W'(CLK_PER_US - 1);
    localparam logic [MS_W-1:0] MS_LAST = MS_W'(US_PER_MS - 1);
    localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DEBOUNCE_MS);
    localparam logic [CH_W-1:0] CH_MAX  = CH_W'(CHASE_MS);
    localparam logic [BL_W-1:0] BL_MAX  = BL_W'(BLINK_MS);

    logic [US_W-1:0]  us_cnt_q, us_cnt_d;
    logic [MS_W-1:0]  ms_cnt_q, ms_cnt_d;
    logic             btn_s1_q, btn_s2_q;
    logic             pause_s1_q, pause_s2_q;
    logic             db_level_q, db_level_d;
    logic             db_prev_q;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    mode_e            mode_q, mode_d;
    logic             mode_change_q, mode_change_d;
    logic [MS_W-1:0]  lvl_q, lvl_d;
    logic             dir_up_q, dir_up_d;
    logic [CH_W-1:0]  ch_cnt_q, ch_cnt_d;
    logic [IDX_W-1:0] ch_idx_q, ch_idx_d;
    logic [BL_W-1:0]  bl_cnt_q, bl_cnt_d;
    logic             blink_on_q, blink_on_d;
    logic [15:0]      light_q, light_d;

    logic tick_us_c, tick_ms_c, press_c, step_c, pwm_c;

    assign tick_us_c = (us_cnt_q == US_LAST);
    assign tick_ms_c = tick_us_c && (ms_cnt_q == MS_LAST);
    assign press_c   = db_level_q && !db_prev_q;
    assign step_c    = tick_ms_c && !pause_s2_q;
    // The ms counter doubles as the PWM ramp; lvl sets the duty threshold.
    assign pwm_c     = dir_up_q ? (ms_cnt_q < lvl_q) : (ms_cnt_q >= lvl_q);

    always_comb begin
        us_cnt_d      = us_cnt_q;
        ms_cnt_d      = ms_cnt_q;
        db_level_d    = db_level_q;
        db_cnt_d      = db_cnt_q;
        mode_d        = mode_q;
        mode_change_d = press_c;
        lvl_d         = lvl_q;
        dir_up_d      = dir_up_q;
        ch_cnt_d      = ch_cnt_q;
        ch_idx_d      = ch_idx_q;
        bl_cnt_d      = bl_cnt_q;
        blink_on_d    = blink_on_q;
        light_d       = 16'h0000;

        us_cnt_d = tick_us_c ? '0 : us_cnt_q + US_W'(1);
        if (tick_us_c) begin
            ms_cnt_d = (ms_cnt_q == MS_LAST) ? '0 : ms_cnt_q + MS_W'(1);
        end

        // Debouncer: accept a new level after DEBOUNCE_MS consecutive differing samples.
        if (tick_ms_c) begin
            if (btn_s2_q == db_level_q) begin
                db_cnt_d = '0;
            end else if (db_cnt_q + DB_W'(1) == DB_MAX) begin
                db_level_d = btn_s2_q;
                db_cnt_d   = '0;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end

        if (press_c) begin
            unique case (mode_q)
                MODE_OFF:    mode_d = MODE_BREATH;
                MODE_BREATH: mode_d = MODE_CHASE;
                MODE_CHASE:  mode_d = MODE_BLINK;
                MODE_BLINK:  mode_d = MODE_OFF;
            endcase
        end

        // Mode entry reset takes priority over any effect step in the same cycle.
        if (press_c) begin
            lvl_d      = '0;
            dir_up_d   = 1'b1;
            ch_cnt_d   = '0;
            ch_idx_d   = '0;
            bl_cnt_d   = '0;
            blink_on_d = 1'b1;
        end else if (step_c) begin
            unique case (mode_q)
                MODE_BREATH: begin
                    if (lvl_q == MS_LAST) begin
                        lvl_d    = '0;
                        dir_up_d = !dir_up_q;
                    end else begin
                        lvl_d = lvl_q + MS_W'(1);
                    end
                end
                MODE_CHASE: begin
                    if (ch_cnt_q + CH_W'(1) == CH_MAX) begin
                        ch_cnt_d = '0;
                        ch_idx_d = ch_idx_q + IDX_W'(1);
                    end else begin
                        ch_cnt_d = ch_cnt_q + CH_W'(1);
                    end
                end
                MODE_BLINK: begin
                    if (bl_cnt_q + BL_W'(1) == BL_MAX) begin
                        bl_cnt_d   = '0;
                        blink_on_d = !blink_on_q;
                    end else begin
                        bl_cnt_d = bl_cnt_q + BL_W'(1);
                    end
                end
                MODE_OFF: ;
            endcase
        end

        unique case (mode_q)
            MODE_OFF:    light_d = 16'h0000;
            MODE_BREATH: light_d = {16{pwm_c}};
            MODE_CHASE:  light_d = 16'h0001 << ch_idx_q;
            MODE_BLINK:  light_d = {16{blink_on_q}};
        endcase
    end

    always_ff @(posedge system_clk) begin
        if (rst) begin
            us_cnt_q      <= '0;
            ms_cnt_q      <= '0;
            btn_s1_q      <= 1'b0;
            btn_s2_q      <= 1'b0;
            pause_s1_q    <= 1'b0;
            pause_s2_q    <= 1'b0;
            db_level_q    <= 1'b0;
            db_prev_q     <= 1'b0;
            db_cnt_q      <= '0;
            mode_q        <= MODE_OFF;
            mode_change_q <= 1'b0;
            lvl_q         <= '0;
            dir_up_q      <= 1'b1;
            ch_cnt_q      <= '0;
            ch_idx_q      <= '0;
            bl_cnt_q      <= '0;
            blink_on_q    <= 1'b1;
            light_q       <= 16'h0000;
        end else begin
            us_cnt_q      <= us_cnt_d;
            ms_cnt_q      <= ms_cnt_d;
            btn_s1_q      <= btn_next;
            btn_s2_q      <= btn_s1_q;
            pause_s1_q    <= pause;
            pause_s2_q    <= pause_s1_q;
            db_level_q    <= db_level_d;
            db_prev_q     <= db_level_q;
            db_cnt_q      <= db_cnt_d;
            mode_q        <= mode_d;
            mode_change_q <= mode_change_d;
            lvl_q         <= lvl_d;
            dir_up_q      <= dir_up_d;
            ch_cnt_q      <= ch_cnt_d;
            ch_idx_q      <= ch_idx_d;
            bl_cnt_q      <= bl_cnt_d;
            blink_on_q    <= blink_on_d;
            light_q       <= light_d;
        end
    end

    assign mode        = mode_q;
    assign mode_change = mode_change_q;
    assign light       = light_q;

endmodule

// File: tb/tb_led_effect_sequencer.sv
// Directed bench for led_effect_sequencer with a scaled timebase (one ms tick
// every 16 cycles); expected LED patterns come from a small cycle-level model.
module tb_led_effect_sequencer;

    logic        system_clk = 1'b0;
    logic        rst        = 1'b1;
    logic        btn_next   = 1'b0;
    logic        pause      = 1'b0;
    logic [1:0]  mode;
    logic        mode_change;
    logic [15:0] light;

    int n_cmp = 0;
    int n_err = 0;
    int tcyc  = 0;

    led_effect_sequencer #(
        .CLK_PER_US (2),
        .US_PER_MS  (8),
        .DEBOUNCE_MS(2),
        .CHASE_MS   (1),
        .BLINK_MS   (2)
    ) dut (
        .system_clk (system_clk),
        .rst        (rst),
        .btn_next   (btn_next),
        .pause      (pause),
        .mode       (mode),
        .mode_change(mode_change),
        .light      (light)
    );

    always #5 system_clk = ~system_clk;

    // Cycles since the last reset; ms ticks fall on cycles where tcyc % 16 == 15.
    always @(posedge system_clk) begin
        if (rst) tcyc <= 0;
        else     tcyc <= tcyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int count_ticks(input int lo, input int hi);
        if (hi < lo) return 0;
        return (hi + 1) / 16 - lo / 16;
    endfunction

    function automatic int breath_duty(input int k);
        int lv;
        lv = k % 8;
        return (((k / 8) % 2) == 0) ? 2 * lv : 16 - 2 * lv;
    endfunction

    function automatic logic [15:0] effect_light(input int m, input int k);
        logic [15:0] one;
        one = 16'h0001;
        case (m)
            2:       return one << (k % 16);
            3:       return (((k / 2) % 2) == 0) ? 16'hFFFF : 16'h0000;
            default: return 16'h0000;
        endcase
    endfunction

    // Hold the button 60 cycles, release 60; expect exactly one mode_change.
    task automatic press(input string tag, input int exp_mode, input logic [15:0] exp_first,
                         output int e);
        int pulses;
        int chk_at;
        pulses = 0;
        chk_at = -1;
        e      = -1;
        btn_next = 1'b1;
        for (int i = 0; i < 120; i++) begin
            @(negedge system_clk);
            if (i == 60) btn_next = 1'b0;
            if (i == chk_at) check({tag, "_first_light"}, 32'(light), 32'(exp_first));
            if (mode_change) begin
                pulses++;
                if (e < 0) begin
                    e      = tcyc;
                    chk_at = i + 1;
                end
            end
        end
        check({tag, "_pulses"}, pulses, 1);
        check({tag, "_mode"}, 32'(mode), exp_mode);
    endtask

    // Count lit cycles per 16-cycle ms window (light lags the PWM by one cycle).
    task automatic breath_windows(input string tag, input int e, input int nwin);
        int guard;
        int w0;
        int cnt;
        guard = 0;
        while (!(((tcyc % 16) == 0) && (tcyc > e)) && (guard < 40)) begin
            @(negedge system_clk);
            guard++;
        end
        if (guard >= 40) check({tag, "_align_timeout"}, guard, 0);
        w0 = tcyc;
        for (int w = 0; w < nwin; w++) begin
            cnt = 0;
            for (int j = 0; j < 16; j++) begin
                @(negedge system_clk);
                if (light == 16'hFFFF) cnt++;
            end
            check($sformatf("%s_win%0d", tag, w), cnt, breath_duty(count_ticks(e, w0 + 16 * w - 1)));
        end
        check({tag, "_mode"}, 32'(mode), 1);
    endtask

    // Cycle-by-cycle check of CHASE/BLINK; pause reaches the effect two cycles late.
    task automatic run_effect(input string tag, input int exp_mode, input int e, input int ncyc,
                              input int p_from, input int p_to, input int stop_k);
        int s_prev;
        int s_cur;
        bit pd0, pd1, pd2;
        s_prev = count_ticks(e, tcyc - 2);
        s_cur  = count_ticks(e, tcyc - 1);
        pd0 = pause;
        pd1 = pause;
        pd2 = pause;
        for (int i = 0; i < ncyc; i++) begin
            check($sformatf("%s_c%0d", tag, i), 32'(light), 32'(effect_light(exp_mode, s_prev)));
            pause = (i >= p_from) && (i < p_to);
            pd2 = pd1;
            pd1 = pd0;
            pd0 = pause;
            s_prev = s_cur;
            if (((tcyc % 16) == 15) && !pd2) s_cur++;
            if (s_cur == stop_k) break;
            @(negedge system_clk);
        end
        check({tag, "_mode"}, 32'(mode), exp_mode);
    endtask

    initial begin
        int e;
        int t1, t2, pulses, bad, guard;

        // 1. reset and idle
        rst = 1'b1;
        repeat (3) @(posedge system_clk);
        @(negedge system_clk);
        check("rst_mode", 32'(mode), 0);
        check("rst_light", 32'(light), 0);
        check("rst_mode_change", 32'(mode_change), 0);
        rst = 1'b0;
        t1 = -1;
        t2 = -1;
        pulses = 0;
        bad = 0;
        for (int i = 0; i < 500; i++) begin
            if (mode_change) pulses++;
            if (mode != 2'd0 || light != 16'h0000) bad++;
            if (dut.tick_ms_c) begin
                if (t1 < 0)      t1 = tcyc;
                else if (t2 < 0) t2 = tcyc;
            end
            @(negedge system_clk);
        end
        check("idle_pulses", pulses, 0);
        check("idle_nonzero", bad, 0);
        check("tick_ms_period", t2 - t1, 16);
        check("tick_ms_phase", t1 % 16, 15);

        // 2. debounce: a 20-cycle glitch straddles only one ms sample
        guard = 0;
        while (((tcyc % 16) != 15) && (guard < 20)) begin
            @(negedge system_clk);
            guard++;
        end
        btn_next = 1'b1;
        repeat (20) @(negedge system_clk);
        btn_next = 1'b0;
        pulses = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge system_clk);
            if (mode_change) pulses++;
        end
        check("glitch_pulses", pulses, 0);
        check("glitch_mode", 32'(mode), 0);
        press("p1", 1, 16'h0000, e);
        press("p2", 2, 16'h0001, e);
        press("p3", 3, 16'hFFFF, e);
        press("p4", 0, 16'h0000, e);
        press("p5", 1, 16'h0000, e);

        // 3. breath duty over a direction flip
        rst = 1'b1;
        @(negedge system_clk);
        rst = 1'b0;
        check("rst2_mode", 32'(mode), 0);
        press("breath", 1, 16'h0000, e);
        breath_windows("breath", e, 11);

        // 4. chase through a full wrap
        press("chase", 2, 16'h0001, e);
        run_effect("chase", 2, e, 300, 1000, 1000, -1);

        // 5. blink with a 200-cycle pause
        press("blink", 3, 16'hFFFF, e);
        run_effect("blink", 3, e, 450, 60, 260, -1);

        // 6. reset in the middle of a chase
        press("off", 0, 16'h0000, e);
        press("breath2", 1, 16'h0000, e);
        press("chase2", 2, 16'h0001, e);
        run_effect("chase2", 2, e, 200, 1000, 1000, 9);
        @(negedge system_clk);
        check("pre_rst_light", 32'(light), 32'h0100);
        rst = 1'b1;
        @(negedge system_clk);
        rst = 1'b0;
        check("midrst_mode", 32'(mode), 0);
        check("midrst_light", 32'(light), 0);
        check("midrst_mode_change", 32'(mode_change), 0);
        press("breath3", 1, 16'h0000, e);
        breath_windows("breath3", e, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

endmodule
